// File: rtl/pipe_latch.sv
// Elastic DEPTH-stage valid/ready pipeline register; a word needs DEPTH-1 edges from stage 0 to out.
// Backpressure: each stage stalls only when it and every stage after it are full and out_ready=0.
module pipe_latch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] en;
  logic             accept;

  // Stall propagates upstream only through a contiguous run of full stages.
  always_comb begin
    logic stall;
    en    = '0;
    stall = !out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      stall = stall & v_q[i];
      en[i] = !stall;
    end
  end

  assign in_ready = en[0] & !flush & reset;
  assign accept   = in_valid & in_ready;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (en[0]) begin
        v_d[0] = accept;
        if (accept) d_d[0] = in;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (en[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) d_d[i] = d_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
      d_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign out       = d_q[DEPTH-1];
  assign out_valid = v_q[DEPTH-1];
  assign count     = CW'($countones(v_q));

endmodule
